// File: rtl/vrf_pkg.sv
// Shared types and constants for the masked vector register file.
package vrf_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } vrf_state_e;

  localparam int DEFAULT_LANE_BITS = 32;

endpackage

// File: rtl/hot_bit.sv
// Binary index to one-hot decoder.
module Hot_Bit #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [W-1:0] index,
  output logic [N-1:0] hot
);

  always_comb begin
    hot = '0;
    hot[index] = 1'b1;
  end

endmodule

// File: rtl/vrf_lane_merge.sv
// Lane-granular merge: lanes with mask set take new_data, the rest keep old_data.
module Vrf_Lane_Merge #(
  parameter int BITS      = 128,
  parameter int LANE_BITS = 32,
  parameter int LANES     = BITS / LANE_BITS
) (
  input  logic [BITS-1:0]  old_data,
  input  logic [BITS-1:0]  new_data,
  input  logic [LANES-1:0] mask,
  output logic [BITS-1:0]  merged
);

  always_comb begin
    merged = old_data;
    for (int k = 0; k < LANES; k++) begin
      if (mask[k]) begin
        merged[k*LANE_BITS +: LANE_BITS] = new_data[k*LANE_BITS +: LANE_BITS];
      end
    end
  end

endmodule

// File: rtl/vreg_file_masked.sv
// Vector register file with per-lane write masks, write-first registered reads
// and a sequential clear that walks registers 1..DEPTH-1, one per cycle.
module vreg_file_masked
  import vrf_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int BITS      = 128,
  parameter int LANE_BITS = DEFAULT_LANE_BITS,
  localparam int AW       = $clog2(DEPTH),
  localparam int LANES    = BITS / LANE_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    address1,
  input  logic [AW-1:0]    address2,
  input  logic [AW-1:0]    addressw,
  input  logic [BITS-1:0]  writeData,
  input  logic [LANES-1:0] writeMask,
  input  logic             writeEn,
  input  logic             clearReq,
  output logic             clearBusy,
  output logic [BITS-1:0]  read1,
  output logic [BITS-1:0]  read2
);

  logic [BITS-1:0] mem [DEPTH];
  vrf_state_e      state;
  logic [AW-1:0]   counter;

  logic             write_fire;
  logic [DEPTH-1:0] write_hot;
  logic [BITS-1:0]  write_merged;
  logic [BITS-1:0]  bypass1, bypass2;
  logic             clear_hit1, clear_hit2;
  logic [BITS-1:0]  read1_next, read2_next;

  // A pending or running clear swallows the write; register 0 is never written.
  assign write_fire = writeEn && (state == IDLE) && !clearReq && (addressw != '0);

  Hot_Bit #(.N(DEPTH), .W(AW)) u_write_decode (
    .index (addressw),
    .hot   (write_hot)
  );

  Vrf_Lane_Merge #(.BITS(BITS), .LANE_BITS(LANE_BITS), .LANES(LANES)) u_write_merge (
    .old_data (mem[addressw]),
    .new_data (writeData),
    .mask     (writeMask),
    .merged   (write_merged)
  );

  // Bypass merges only the lanes of a write landing on the same address this edge.
  Vrf_Lane_Merge #(.BITS(BITS), .LANE_BITS(LANE_BITS), .LANES(LANES)) u_bypass1 (
    .old_data (mem[address1]),
    .new_data (writeData),
    .mask     (writeMask & {LANES{write_fire && (addressw == address1)}}),
    .merged   (bypass1)
  );

  Vrf_Lane_Merge #(.BITS(BITS), .LANE_BITS(LANE_BITS), .LANES(LANES)) u_bypass2 (
    .old_data (mem[address2]),
    .new_data (writeData),
    .mask     (writeMask & {LANES{write_fire && (addressw == address2)}}),
    .merged   (bypass2)
  );

  assign clear_hit1 = (state == CLEAR) && (counter == address1);
  assign clear_hit2 = (state == CLEAR) && (counter == address2);
  assign read1_next = ((address1 == '0) || clear_hit1) ? '0 : bypass1;
  assign read2_next = ((address2 == '0) || clear_hit2) ? '0 : bypass2;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      read1     <= '0;
      read2     <= '0;
      state     <= IDLE;
      counter   <= '0;
      clearBusy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clearReq) begin
            state     <= CLEAR;
            counter   <= AW'(1);
            clearBusy <= 1'b1;
          end
        end
        CLEAR: begin
          counter <= counter + AW'(1);
          if (counter == AW'(DEPTH - 1)) begin
            state     <= IDLE;
            clearBusy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      for (int i = 0; i < DEPTH; i++) begin
        if (write_fire && write_hot[i]) begin
          mem[i] <= write_merged;
        end else if ((state == CLEAR) && (counter == AW'(i))) begin
          mem[i] <= '0;
        end
      end

      read1 <= read1_next;
      read2 <= read2_next;
    end
  end

endmodule

// File: tb/tb_vreg_file_masked.sv
// Directed bench for vreg_file_masked with a behavioural register-file model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_vreg_file_masked;

  logic         clk;
  logic         rst;
  logic [3:0]   address1, address2, addressw;
  logic [127:0] writeData;
  logic [3:0]   writeMask;
  logic         writeEn;
  logic         clearReq;
  logic         clearBusy;
  logic [127:0] read1, read2;

  int checkCount = 0;
  int errorCount = 0;

  vreg_file_masked #(.DEPTH(16), .BITS(128), .LANE_BITS(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .address1  (address1),
    .address2  (address2),
    .addressw  (addressw),
    .writeData (writeData),
    .writeMask (writeMask),
    .writeEn   (writeEn),
    .clearReq  (clearReq),
    .clearBusy (clearBusy),
    .read1     (read1),
    .read2     (read2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: an array of registers updated by the rules, reads taken after the update.
  logic [127:0] modelMem [16];
  bit           modelClearing = 0;
  int           modelNextClear = 0;
  logic [127:0] expRead1, expRead2;
  bit           expBusy;
  bit           modelValid = 0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) modelMem[i] = '0;
      modelClearing = 0;
      expRead1 = '0;
      expRead2 = '0;
      expBusy = 0;
      modelValid = 1;
    end else begin
      if (modelClearing) begin
        modelMem[modelNextClear] = '0;
        modelNextClear++;
        if (modelNextClear == 16) modelClearing = 0;
      end else if (clearReq) begin
        modelClearing = 1;
        modelNextClear = 1;
      end else if (writeEn && addressw != 0) begin
        for (int k = 0; k < 4; k++)
          if (writeMask[k]) modelMem[addressw][k*32 +: 32] = writeData[k*32 +: 32];
      end
      expRead1 = modelMem[address1];
      expRead2 = modelMem[address2];
      expBusy = modelClearing;
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("model read1", read1, expRead1);
      checkOutput("model read2", read2, expRead2);
      checkOutput("model clearBusy", {127'b0, clearBusy}, {127'b0, expBusy});
    end
  end

  // Drives one cycle's inputs at the falling edge; the next rising edge consumes them.
  task automatic applyStimulus(input logic we, input logic [3:0] aw, input logic [127:0] data,
                               input logic [3:0] mask, input logic clr,
                               input logic [3:0] a1, input logic [3:0] a2);
    @(negedge clk);
    writeEn   = we;
    addressw  = aw;
    writeData = data;
    writeMask = mask;
    clearReq  = clr;
    address1  = a1;
    address2  = a2;
  endtask

  task automatic afterEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic fillRegisters();
    for (int r = 1; r < 16; r++)
      applyStimulus(1, 4'(r), {4{8'(r), 24'hC0FFEE}}, 4'hF, 0, 4'(r), 0);
  endtask

  int busyCycles;

  initial begin
    rst = 1; writeEn = 0; clearReq = 0; addressw = 0; writeData = '0;
    writeMask = 0; address1 = 0; address2 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;

    $display("[TB] reset read sweep");
    for (int a = 0; a < 16; a++) begin
      applyStimulus(0, 0, '0, 0, 0, 4'(a), 4'(15 - a));
      afterEdge();
      checkOutput("reset read1", read1, 128'h0);
      checkOutput("reset read2", read2, 128'h0);
      checkOutput("reset clearBusy", {127'b0, clearBusy}, 128'h0);
    end

    $display("[TB] masked writes to r5");
    applyStimulus(1, 5, 128'h11112222_33334444_55556666_77778888, 4'b1111, 0, 0, 0);
    applyStimulus(1, 5, 128'hAAAAAAAA_CCCCCCCC_DDDDDDDD_BBBBBBBB, 4'b1001, 0, 0, 0);
    applyStimulus(0, 0, '0, 0, 0, 5, 5);
    afterEdge();
    checkOutput("r5 merge read1", read1, 128'hAAAAAAAA_33334444_55556666_BBBBBBBB);
    checkOutput("r5 merge read2", read2, 128'hAAAAAAAA_33334444_55556666_BBBBBBBB);
    applyStimulus(1, 5, {128{1'b1}}, 4'b0000, 0, 5, 0);
    afterEdge();
    checkOutput("r5 mask zero", read1, 128'hAAAAAAAA_33334444_55556666_BBBBBBBB);

    $display("[TB] same-cycle bypass on r3");
    applyStimulus(1, 3, {128{1'b1}}, 4'b0100, 0, 3, 5);
    afterEdge();
    checkOutput("r3 bypass", read1, 128'h00000000_FFFFFFFF_00000000_00000000);

    $display("[TB] write to r0 ignored");
    applyStimulus(1, 0, {4{32'hDEADBEEF}}, 4'hF, 0, 0, 0);
    afterEdge();
    checkOutput("r0 bypass", read1, 128'h0);
    applyStimulus(0, 0, '0, 0, 0, 0, 0);
    afterEdge();
    checkOutput("r0 read", read2, 128'h0);

    $display("[TB] full clear sequence");
    fillRegisters();
    applyStimulus(0, 0, '0, 0, 0, 7, 15);
    afterEdge();
    checkOutput("r7 filled", read1, {4{8'h07, 24'hC0FFEE}});
    applyStimulus(1, 7, {4{32'h12345678}}, 4'hF, 1, 7, 3);
    busyCycles = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk);
      #1;
      if (clearBusy) busyCycles++;
      else break;
      @(negedge clk);
      writeEn  = 0;
      clearReq = (cyc == 6);
      address1 = 4'(cyc);
      address2 = 7;
    end
    checkOutput("clear busy cycles", 128'(busyCycles), 128'd15);
    for (int a = 0; a < 16; a++) begin
      applyStimulus(0, 0, '0, 0, 0, 4'(a), 4'(a));
      afterEdge();
      checkOutput("post clear read", read1, 128'h0);
    end

    $display("[TB] reset aborts clear");
    fillRegisters();
    applyStimulus(0, 0, '0, 0, 1, 9, 12);
    repeat (4) applyStimulus(0, 0, '0, 0, 0, 9, 12);
    @(negedge clk);
    rst = 1;
    afterEdge();
    checkOutput("abort clearBusy", {127'b0, clearBusy}, 128'h0);
    checkOutput("abort read1", read1, 128'h0);
    @(negedge clk);
    rst = 0;
    for (int a = 0; a < 16; a++) begin
      applyStimulus(0, 0, '0, 0, 0, 4'(a), 4'(15 - a));
      afterEdge();
      checkOutput("post abort read", read1, 128'h0);
    end
    applyStimulus(1, 2, 128'h01234567_89ABCDEF_FEDCBA98_76543210, 4'hF, 0, 0, 0);
    applyStimulus(0, 0, '0, 0, 0, 2, 0);
    afterEdge();
    checkOutput("idle after abort", read1, 128'h01234567_89ABCDEF_FEDCBA98_76543210);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
